mem_read_arbiter: RTL and testbench

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_read_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_read_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: two-requester burst read arbiter sharing one memory read port.
// Each accepted burst issues one read per beat at stride BANDWIDTH.
// Read data is returned to the granted requester one cycle after each read.
// Optional build macro MEM_ARB_FIXED_PRIO_EN makes requester 0 win every tie.
// Without it, ties are resolved round-robin.
//
// state | meaning
// IDLE  | waiting for a request; may accept one per cycle
// BURST | issuing the reads of the accepted burst; requests ignored

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module mem_read_arbiter #(
    parameter int MAX_BEATS = 16,
    parameter int LEN_WIDTH = $clog2(MAX_BEATS + 1)
) (
    input  logic                                  clock,
    input  logic                                  reset_n,
    input  logic [1:0]                            req_valid,
    input  logic [1:0][`ADDR_WIDTH-1:0]           req_addr,
    input  logic [1:0][LEN_WIDTH-1:0]             req_len,
    output logic [1:0]                            req_ready,
    output logic                                  mem_read,
    output logic [`ADDR_WIDTH-1:0]                mem_addr,
    input  logic [`BANDWIDTH-1:0][`DATA_WIDTH-1:0] mem_data,
    output logic [1:0]                            rsp_valid,
    output logic [`BANDWIDTH-1:0][`DATA_WIDTH-1:0] rsp_data,
    output logic                                  rsp_last,
    output logic                                  busy
);
    localparam int AW = `ADDR_WIDTH;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state;
    logic                  id;
    logic [LEN_WIDTH-1:0]  beats_left;
    logic                  grant_id;
    logic                  accept;
    logic [AW-1:0]         grant_addr;
    logic [LEN_WIDTH-1:0]  grant_len_raw;
    logic [LEN_WIDTH-1:0]  grant_len;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic                  last_grant;
`endif

    // Pick the winner, raise its accept pulse, and clamp its burst length.
    always_comb begin
        grant_id = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            grant_id = 1'b0;
`else
            grant_id = ~last_grant;
`endif
        end else begin
            grant_id = req_valid[1];
        end
        // The reset gate keeps req_ready low while reset_n is held, even with requests pending.
        accept        = reset_n && (state == IDLE) && (req_valid != 2'b00);
        req_ready     = accept ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
        grant_addr    = req_addr[grant_id];
        grant_len_raw = req_len[grant_id];
        grant_len     = (grant_len_raw > LEN_WIDTH'(MAX_BEATS)) ? LEN_WIDTH'(MAX_BEATS)
                                                                : grant_len_raw;
    end

    // Burst sequencer: beats_left counts down to terminal count zero on the final read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            id         <= 1'b0;
            beats_left <= '0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            rsp_valid  <= 2'b00;
            rsp_last   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            rsp_valid <= mem_read ? (id ? 2'b10 : 2'b01) : 2'b00;
            rsp_last  <= mem_read && (beats_left == '0);
            case (state)
                IDLE: begin
                    if (accept) begin
                        id <= grant_id;
`ifndef MEM_ARB_FIXED_PRIO_EN
                        last_grant <= grant_id;
`endif
                        // A zero-length burst is consumed here with no read issued.
                        if (grant_len != '0) begin
                            state      <= BURST;
                            mem_read   <= 1'b1;
                            mem_addr   <= grant_addr;
                            beats_left <= grant_len - LEN_WIDTH'(1);
                        end
                    end
                end
                BURST: begin
                    if (beats_left == '0) begin
                        state    <= IDLE;
                        mem_read <= 1'b0;
                        mem_addr <= '0;
                    end else begin
                        beats_left <= beats_left - LEN_WIDTH'(1);
                        mem_addr   <= mem_addr + AW'(`BANDWIDTH);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_data = mem_data;
    assign busy     = (state != IDLE) || (rsp_valid != 2'b00);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Testbench for mem_read_arbiter. It uses ADDR_WIDTH=8, BANDWIDTH=4 and DATA_WIDTH=8.
// With MEM_ARB_FIXED_PRIO_EN defined, the expected grants switch to fixed priority.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_mem_read_arbiter;
    localparam int LW = 5;

    typedef struct {
        logic [1:0] valid;
        logic [7:0] a0;
        logic [4:0] l0;
        logic [7:0] a1;
        logic [4:0] l1;
        logic [1:0] exp_ready;
        logic [7:0] exp_base;
        int         exp_beats;
    } vec_t;

    logic                                  clock = 1'b0;
    logic                                  reset_n;
    logic [1:0]                            req_valid;
    logic [1:0][`ADDR_WIDTH-1:0]           req_addr;
    logic [1:0][LW-1:0]                    req_len;
    logic [1:0]                            req_ready;
    logic                                  mem_read;
    logic [`ADDR_WIDTH-1:0]                mem_addr;
    logic [`BANDWIDTH-1:0][`DATA_WIDTH-1:0] mem_data = '0;
    logic [1:0]                            rsp_valid;
    logic [`BANDWIDTH-1:0][`DATA_WIDTH-1:0] rsp_data;
    logic                                  rsp_last;
    logic                                  busy;

    int checks   = 0;
    int failures = 0;

    vec_t tbl[12];

    mem_read_arbiter #(.MAX_BEATS(16), .LEN_WIDTH(LW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_ready (req_ready),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] mdat(input logic [7:0] a, input int lane);
        return a * 8'd3 + 8'(lane * 17) + 8'hA5;
    endfunction

    function automatic logic [31:0] mline(input logic [7:0] a);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[l*8 +: 8] = mdat(a, l);
        return r;
    endfunction

    // Memory model: one-cycle read latency, data is a fixed function of the address.
    always @(posedge clock)
        for (int l = 0; l < 4; l++) mem_data[l] <= mdat(mem_addr, l);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive a request now, expect immediate acceptance, then follow the burst cycle by cycle.
    task automatic run_entry(input vec_t v, input string tag);
        int cnt;
        logic [7:0] ea;
        req_valid   = v.valid;
        req_addr[0] = v.a0;
        req_len[0]  = v.l0;
        req_addr[1] = v.a1;
        req_len[1]  = v.l1;
        #1;
        cnt = 0;
        while (req_ready == 2'b00 && cnt < 20) begin
            @(negedge clock);
            #1;
            cnt++;
        end
        check({tag, "_accept_wait"}, 64'(cnt), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'(v.exp_ready));
        for (int k = 1; k <= v.exp_beats + 1; k++) begin
            @(negedge clock);
            if (k == 1) req_valid = req_valid & ~v.exp_ready;
            #1;
            ea = v.exp_base + 8'(4 * (k - 1));
            check($sformatf("%s_mem_read_k%0d", tag, k), 64'(mem_read), 64'(k <= v.exp_beats));
            check($sformatf("%s_mem_addr_k%0d", tag, k), 64'(mem_addr),
                  (k <= v.exp_beats) ? 64'(ea) : 64'd0);
            check($sformatf("%s_rsp_valid_k%0d", tag, k), 64'(rsp_valid),
                  (k >= 2) ? 64'(v.exp_ready) : 64'd0);
            check($sformatf("%s_rsp_last_k%0d", tag, k), 64'(rsp_last),
                  64'((k == v.exp_beats + 1) && (v.exp_beats > 0)));
            check($sformatf("%s_busy_k%0d", tag, k), 64'(busy), 64'(v.exp_beats > 0));
            if (k <= v.exp_beats)
                check($sformatf("%s_ready_in_burst_k%0d", tag, k), 64'(req_ready), 64'd0);
            if (k >= 2)
                check($sformatf("%s_rsp_data_k%0d", tag, k), 64'(rsp_data),
                      64'(mline(v.exp_base + 8'(4 * (k - 2)))));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_mem_read"},  64'(mem_read),  64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr),  64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_last"},  64'(rsp_last),  64'd0);
        check({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        vec_t rv;
        //          valid  a0     l0     a1     l1     ready  base   beats
        tbl[0]  = '{2'b11, 8'h00, 5'd1,  8'h40, 5'd1,  2'b01, 8'h00, 1};
`ifdef MEM_ARB_FIXED_PRIO_EN
        tbl[1]  = '{2'b11, 8'h00, 5'd1,  8'h40, 5'd1,  2'b01, 8'h00, 1};
`else
        tbl[1]  = '{2'b11, 8'h00, 5'd1,  8'h40, 5'd1,  2'b10, 8'h40, 1};
`endif
        tbl[2]  = '{2'b10, 8'h00, 5'd1,  8'h40, 5'd1,  2'b10, 8'h40, 1};
        tbl[3]  = '{2'b01, 8'h00, 5'd2,  8'h00, 5'd0,  2'b01, 8'h00, 2};
        tbl[4]  = '{2'b01, 8'hFC, 5'd2,  8'h00, 5'd0,  2'b01, 8'hFC, 2};
        tbl[5]  = '{2'b10, 8'h00, 5'd0,  8'h33, 5'd0,  2'b10, 8'h33, 0};
        tbl[6]  = '{2'b11, 8'h08, 5'd0,  8'h50, 5'd3,  2'b01, 8'h08, 0};
`ifdef MEM_ARB_FIXED_PRIO_EN
        tbl[7]  = '{2'b11, 8'h08, 5'd0,  8'h50, 5'd3,  2'b01, 8'h08, 0};
`else
        tbl[7]  = '{2'b11, 8'h08, 5'd0,  8'h50, 5'd3,  2'b10, 8'h50, 3};
`endif
        tbl[8]  = '{2'b01, 8'h80, 5'd31, 8'h00, 5'd0,  2'b01, 8'h80, 16};
`ifdef MEM_ARB_FIXED_PRIO_EN
        tbl[9]  = '{2'b11, 8'h00, 5'd16, 8'd70, 5'd16, 2'b01, 8'h00, 16};
        tbl[10] = '{2'b11, 8'h00, 5'd16, 8'd70, 5'd16, 2'b01, 8'h00, 16};
        tbl[11] = '{2'b11, 8'h00, 5'd16, 8'd70, 5'd16, 2'b01, 8'h00, 16};
`else
        tbl[9]  = '{2'b11, 8'h00, 5'd16, 8'd70, 5'd16, 2'b10, 8'd70, 16};
        tbl[10] = '{2'b11, 8'h00, 5'd16, 8'd70, 5'd16, 2'b01, 8'h00, 16};
        tbl[11] = '{2'b11, 8'h00, 5'd16, 8'd70, 5'd16, 2'b10, 8'd70, 16};
`endif

        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_addr  = '0;
        req_len   = '0;
        repeat (2) @(negedge clock);
        req_valid   = tbl[0].valid;
        req_addr[0] = tbl[0].a0;
        req_len[0]  = tbl[0].l0;
        req_addr[1] = tbl[0].a1;
        req_len[1]  = tbl[0].l1;
        #1;
        check_all_zero("reset_state");
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) run_entry(tbl[i], $sformatf("v%0d", i));

        // Reset in the middle of a long burst, then a fresh burst from a new base.
        req_valid   = 2'b01;
        req_addr[0] = 8'h20;
        req_len[0]  = 5'd8;
        req_valid[1] = 1'b0;
        #1;
        check("mid_reset_req_ready", 64'(req_ready), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            if (k == 1) req_valid = 2'b00;
            #1;
            check($sformatf("mid_reset_mem_addr_k%0d", k), 64'(mem_addr), 64'(8'h20 + 8'(4 * (k - 1))));
        end
        req_valid = 2'b01;
        reset_n   = 1'b0;
        #1;
        check_all_zero("reset_asserted");
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            #1;
            check($sformatf("in_reset_rsp_valid_c%0d", c), 64'(rsp_valid), 64'd0);
            check($sformatf("in_reset_mem_read_c%0d", c), 64'(mem_read), 64'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        rv = '{2'b01, 8'h60, 5'd2, 8'h00, 5'd0, 2'b01, 8'h60, 2};
        run_entry(rv, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
